// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate truth-table checker.
//   state_e    : checker FSM states
//   TRUTH_*    : 2-input truth tables, bit i = expected output for input index i ({A,B})
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] TRUTH_NOR  = 4'b0001;
  localparam logic [3:0] TRUTH_OR   = 4'b1110;
  localparam logic [3:0] TRUTH_AND  = 4'b1000;
  localparam logic [3:0] TRUTH_NAND = 4'b0111;
  localparam logic [3:0] TRUTH_XOR  = 4'b0110;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : clear to zero (has priority over inc_i)
//   inc_i      : increment by one, holding at all-ones
//   count_o    : current count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps every input vector onto a small combinational DUT, holds each one
// SETTLE cycles, samples the response on the last edge of the hold and
// compares it against TRUTH. Reports pass/fail, mismatch count and the
// first failing vector at the end of the sweep.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a sweep (accepted in IDLE or DONE only)
//   dut_in      : registered stimulus vector to the DUT
//   dut_out     : DUT response
//   busy        : sweep in progress
//   done        : sweep finished, results valid
//   pass        : done and no mismatches
//   err_count   : saturating mismatch count
//   fail_valid  : at least one mismatch captured
//   fail_vec    : first mismatching vector
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned           N_IN   = 2,
  parameter logic [2**N_IN-1:0]    TRUTH  = TRUTH_NOR,
  parameter int unsigned           SETTLE = 2,
  parameter int unsigned           ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [N_IN-1:0]  fail_vec
);

  localparam int unsigned     CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  LAST_VEC = '1;

  state_e           state_q;
  logic [N_IN-1:0]  vec_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             fail_valid_q;
  logic [N_IN-1:0]  fail_vec_q;

  logic sample_d;
  logic mismatch_d;
  logic accept_d;

  assign sample_d   = (state_q == DRIVE) && (cnt_q == LAST_CNT);
  // Case inequality so an X/Z response is scored as a mismatch.
  assign mismatch_d = (dut_out !== TRUTH[vec_q]);
  assign accept_d   = start && (state_q != DRIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= DRIVE;
            vec_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
          end
        end
        DRIVE: begin
          if (cnt_q != LAST_CNT) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            if (mismatch_d && !fail_valid_q) begin
              fail_valid_q <= 1'b1;
              fail_vec_q   <= vec_q;
            end
            if (vec_q == LAST_VEC) begin
              state_q <= DONE;
              vec_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              vec_q <= vec_q + 1'b1;
              cnt_q <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (accept_d),
    .inc_i   (sample_d && mismatch_d),
    .count_o (err_count)
  );

  assign dut_in     = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = done_q && (err_count == '0);
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // A: default NOR checker, response table driven by the bench
  logic       start_a = 1'b0;
  logic [1:0] dut_in_a;
  logic       dut_out_a, busy_a, done_a, pass_a, fv_a;
  logic [7:0] err_a;
  logic [1:0] fvec_a;
  logic [3:0] resp_a = 4'b0001;
  assign dut_out_a = resp_a[dut_in_a];

  gate_truth_checker #(.N_IN(2), .TRUTH(4'b0001), .SETTLE(2), .ERR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_valid(fv_a), .fail_vec(fvec_a));

  // B: 1-bit error counter, OR gate attached
  logic       start_b = 1'b0;
  logic [1:0] dut_in_b;
  logic       dut_out_b, busy_b, done_b, pass_b, fv_b;
  logic [0:0] err_b;
  logic [1:0] fvec_b;
  assign dut_out_b = dut_in_b[1] | dut_in_b[0];

  gate_truth_checker #(.N_IN(2), .TRUTH(4'b0001), .SETTLE(2), .ERR_W(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .fail_valid(fv_b), .fail_vec(fvec_b));

  // C: single-input inverter check, SETTLE=1
  logic       start_c = 1'b0;
  logic [0:0] dut_in_c;
  logic       dut_out_c, busy_c, done_c, pass_c, fv_c;
  logic [7:0] err_c;
  logic [0:0] fvec_c;
  logic [1:0] resp_c = 2'b01;
  assign dut_out_c = resp_c[dut_in_c];

  gate_truth_checker #(.N_IN(1), .TRUTH(2'b01), .SETTLE(1), .ERR_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .dut_in(dut_in_c), .dut_out(dut_out_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .fail_valid(fv_c), .fail_vec(fvec_c));

  // D: 3-input checker, SETTLE=3, 2-bit counter to exercise saturation with random faults
  localparam logic [7:0] TRUTH_D = 8'b1001_0110;
  logic       start_d = 1'b0;
  logic [2:0] dut_in_d;
  logic       dut_out_d, busy_d, done_d, pass_d, fv_d;
  logic [1:0] err_d;
  logic [2:0] fvec_d;
  logic [7:0] resp_d = 8'b1001_0110;
  assign dut_out_d = resp_d[dut_in_d];

  gate_truth_checker #(.N_IN(3), .TRUTH(TRUTH_D), .SETTLE(3), .ERR_W(2)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .dut_in(dut_in_d), .dut_out(dut_out_d),
    .busy(busy_d), .done(done_d), .pass(pass_d), .err_count(err_d),
    .fail_valid(fv_d), .fail_vec(fvec_d));

  // Reference model: mismatches are simply the differing table entries.
  function automatic int n_mism(input logic [7:0] resp, input logic [7:0] truth, input int nvec);
    int c = 0;
    for (int v = 0; v < nvec; v++) if (resp[v] != truth[v]) c++;
    return c;
  endfunction

  function automatic int first_mism(input logic [7:0] resp, input logic [7:0] truth, input int nvec);
    for (int v = 0; v < nvec; v++) if (resp[v] != truth[v]) return v;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({dut_in_a, busy_a, done_a, pass_a, err_a, fv_a, fvec_a} !== '0) begin
      bad++; $display("FAIL reset_a: got %h want 0", {dut_in_a, busy_a, done_a, pass_a, err_a, fv_a, fvec_a});
    end
    total++;
    if ({dut_in_d, busy_d, done_d, pass_d, err_d, fv_d, fvec_d, dut_in_c, done_c, err_b} !== '0) begin
      bad++; $display("FAIL reset_bcd: got %h want 0", {dut_in_d, busy_d, done_d, pass_d, err_d, fv_d, fvec_d, dut_in_c, done_c, err_b});
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  // One full sweep on A; busy_pulse_at >= 0 pulses start mid-sweep.
  task automatic run_a(input logic [3:0] resp, input int busy_pulse_at, input string name);
    int exp_err, exp_fv;
    resp_a  = resp;
    exp_err = n_mism({4'b0, resp}, 8'b0000_0001, 4);
    exp_fv  = first_mism({4'b0, resp}, 8'b0000_0001, 4);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (dut_in_a !== 2'(k / 2)) begin
        bad++; $display("FAIL %s_dut_in k=%0d: got %0d want %0d", name, k, dut_in_a, k / 2);
      end
      total++;
      if ({busy_a, done_a, pass_a} !== 3'b100) begin
        bad++; $display("FAIL %s_busy k=%0d: got %b want 100", name, k, {busy_a, done_a, pass_a});
      end
      start_a = (k == busy_pulse_at);
      step();
      start_a = 1'b0;
    end
    total++;
    if ({busy_a, done_a, dut_in_a} !== 4'b0100) begin
      bad++; $display("FAIL %s_done: got %b want 0100", name, {busy_a, done_a, dut_in_a});
    end
    total++;
    if (err_a !== 8'(exp_err)) begin
      bad++; $display("FAIL %s_err: got %0d want %0d", name, err_a, exp_err);
    end
    total++;
    if (pass_a !== (exp_err == 0)) begin
      bad++; $display("FAIL %s_pass: got %b want %b", name, pass_a, exp_err == 0);
    end
    total++;
    if ({fv_a, fvec_a} !== {exp_err != 0, 2'(exp_fv)}) begin
      bad++; $display("FAIL %s_fail: got %b want %b", name, {fv_a, fvec_a}, {exp_err != 0, 2'(exp_fv)});
    end
  endtask

  task automatic test_nor_and();
    run_a(4'b0001, -1, "nor");
    step();
    run_a(4'b1000, -1, "and");
  endtask

  task automatic test_random_a();
    for (int i = 0; i < 6; i++) begin
      run_a(4'($urandom), -1, "rand_a");
      step();
      total++;
      if (done_a !== 1'b1) begin
        bad++; $display("FAIL rand_a_hold: got %b want 1", done_a);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_a(4'b1010, 3, "busy_pulse");
    // start directly in DONE: done must drop on the accepting edge
    run_a(4'b1010, -1, "b2b");
  endtask

  task automatic test_abort();
    resp_a  = 4'b0000;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 4; k++) step();
    total++;
    if ({dut_in_a, err_a, fv_a} !== {2'b10, 8'd1, 1'b1}) begin
      bad++; $display("FAIL abort_pre: got %h want %h", {dut_in_a, err_a, fv_a}, {2'b10, 8'd1, 1'b1});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({dut_in_a, busy_a, done_a, pass_a, err_a, fv_a, fvec_a} !== '0) begin
      bad++; $display("FAIL abort_async: got %h want 0", {dut_in_a, busy_a, done_a, pass_a, err_a, fv_a, fvec_a});
    end
    step();
    total++;
    if ({dut_in_a, busy_a, done_a, err_a} !== '0) begin
      bad++; $display("FAIL abort_hold: got %h want 0", {dut_in_a, busy_a, done_a, err_a});
    end
    rst_n = 1'b1;
    step();
    run_a(4'b0001, -1, "post_abort");
  endtask

  task automatic test_saturate_or();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int k = 0; k < 7; k++) step();
    total++;
    if (done_b !== 1'b0) begin
      bad++; $display("FAIL sat_early: got %b want 0", done_b);
    end
    step();
    total++;
    if ({done_b, pass_b, err_b, fv_b, fvec_b} !== 6'b101100) begin
      bad++; $display("FAIL sat_or: got %b want 101100", {done_b, pass_b, err_b, fv_b, fvec_b});
    end
  endtask

  task automatic test_inverter();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] r;
      int e;
      r = (i == 0) ? 2'b01 : 2'($urandom);
      resp_c = r;
      e = n_mism({6'b0, r}, 8'b0000_0001, 2);
      start_c = 1'b1;
      step();
      start_c = 1'b0;
      total++;
      if ({dut_in_c, done_c} !== 2'b00) begin
        bad++; $display("FAIL inv_v0: got %b want 00", {dut_in_c, done_c});
      end
      step();
      total++;
      if ({dut_in_c, done_c} !== 2'b10) begin
        bad++; $display("FAIL inv_v1: got %b want 10", {dut_in_c, done_c});
      end
      step();
      total++;
      if ({done_c, pass_c, err_c, fv_c, fvec_c} !== {1'b1, e == 0, 8'(e), e != 0, 1'(first_mism({6'b0, r}, 8'b1, 2))}) begin
        bad++; $display("FAIL inv_res r=%b: got %b want %b", r, {done_c, pass_c, err_c, fv_c, fvec_c},
                        {1'b1, e == 0, 8'(e), e != 0, 1'(first_mism({6'b0, r}, 8'b1, 2))});
      end
    end
  endtask

  task automatic test_three_input();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] r;
      int e, es;
      r = (i == 0) ? TRUTH_D : 8'($urandom);
      resp_d = r;
      e  = n_mism(r, TRUTH_D, 8);
      es = (e > 3) ? 3 : e;
      start_d = 1'b1;
      step();
      start_d = 1'b0;
      for (int k = 0; k < 24; k++) begin
        total++;
        if ({dut_in_d, busy_d, done_d} !== {3'(k / 3), 2'b10}) begin
          bad++; $display("FAIL n3_seq k=%0d: got %b want %b", k, {dut_in_d, busy_d, done_d}, {3'(k / 3), 2'b10});
        end
        step();
      end
      total++;
      if ({done_d, pass_d, err_d, fv_d, fvec_d} !== {1'b1, e == 0, 2'(es), e != 0, 3'(first_mism(r, TRUTH_D, 8))}) begin
        bad++; $display("FAIL n3_res r=%b: got %b want %b", r, {done_d, pass_d, err_d, fv_d, fvec_d},
                        {1'b1, e == 0, 2'(es), e != 0, 3'(first_mism(r, TRUTH_D, 8))});
      end
    end
  endtask

  initial begin
    test_reset();
    test_nor_and();
    test_random_a();
    test_back_to_back();
    test_abort();
    test_saturate_or();
    test_inverter();
    test_three_input();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
